// File: rtl/sp_usb_fifo_dev_pkg.sv
// Shared constants for the device-side USB FIFO bridge.
// Optional loopback mover is enabled with SP_USB_DEV_LOOPBACK_EN.
package sp_usb_fifo_dev_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_DEPTH_LOG2 = 4;
    // Free entries required before rxf_n is released; covers one strobe against a stale flag.
    localparam int unsigned FLAG_SLACK     = 2;

    // Error sources; err is the sticky OR of all of them.
    typedef struct packed {
        logic h2d_ovf;
        logic h2d_udf;
        logic d2h_ovf;
        logic d2h_udf;
    } err_src_t;

    function automatic logic any_err(input err_src_t e);
        return |e;
    endfunction

endpackage

// File: rtl/sp_usb_dev_fifo.sv
// Synchronous first-word-fall-through FIFO with next-state count for registered flags.
module sp_usb_dev_fifo
    import sp_usb_fifo_dev_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned WIDTH      = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count_next,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        // Pop frees a slot first when full; push+pop on empty does neither.
        do_push = push && (!full || pop) && !(pop && empty);
        count_next = count_q;
        if (do_push && !do_pop) begin
            count_next = count_q + ONE_CNT;
        end else if (!do_push && do_pop) begin
            count_next = count_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/sp_usb_fifo_dev.sv
// Device end of the FT245-style synchronous USB FIFO bus: two FIFOs, bus driver, flags, sticky err.
// Define SP_USB_DEV_LOOPBACK_EN to add the loopback port and H2D->D2H mover.
module sp_usb_fifo_dev
    import sp_usb_fifo_dev_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned WIDTH      = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] usb_data,
    output logic             rxf_n,
    output logic             txe_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    input  logic             read,
    output logic             avail,
`ifdef SP_USB_DEV_LOOPBACK_EN
    input  logic             loopback,
`endif
    output logic             err
);
    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] SLACK_CNT = (DEPTH_LOG2 + 1)'(FLAG_SLACK);

    logic                h2d_push, h2d_pop, d2h_push, d2h_pop;
    logic [WIDTH-1:0]    h2d_rdata, d2h_rdata, d2h_wdata;
    logic [DEPTH_LOG2:0] h2d_count_next, d2h_count_next;
    logic                h2d_full, h2d_empty, d2h_full, d2h_empty;
    logic                rxf_n_q, rxf_n_d, txe_n_q, txe_n_d, err_q, err_d;
    err_src_t            err_src;

    assign h2d_push = !wr_n;
    assign d2h_pop  = !rd_n;

`ifdef SP_USB_DEV_LOOPBACK_EN
    logic move;
    assign move = loopback && !h2d_empty && !d2h_full;

    always_comb begin
        h2d_pop   = loopback ? move : read;
        d2h_push  = loopback ? move : write;
        d2h_wdata = loopback ? h2d_rdata : din;
        avail     = !loopback && !h2d_empty;
        full      = loopback || d2h_full;
    end
`else
    always_comb begin
        h2d_pop   = read;
        d2h_push  = write;
        d2h_wdata = din;
        avail     = !h2d_empty;
        full      = d2h_full;
    end
`endif

    sp_usb_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_h2d (
        .clk        (clk),
        .rst        (rst),
        .push       (h2d_push),
        .pop        (h2d_pop),
        .wdata      (usb_data),
        .rdata      (h2d_rdata),
        .count_next (h2d_count_next),
        .full       (h2d_full),
        .empty      (h2d_empty)
    );

    sp_usb_dev_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) u_d2h (
        .clk        (clk),
        .rst        (rst),
        .push       (d2h_push),
        .pop        (d2h_pop),
        .wdata      (d2h_wdata),
        .rdata      (d2h_rdata),
        .count_next (d2h_count_next),
        .full       (d2h_full),
        .empty      (d2h_empty)
    );

    assign usb_data = (!rd_n && !d2h_empty) ? d2h_rdata : {WIDTH{1'bz}};
    assign dout     = h2d_rdata;

    always_comb begin
        err_src.h2d_ovf = h2d_push && h2d_full && !h2d_pop;
        err_src.h2d_udf = h2d_pop && h2d_empty;
        err_src.d2h_ovf = d2h_push && d2h_full && !d2h_pop;
        err_src.d2h_udf = d2h_pop && d2h_empty;
        err_d   = err_q | any_err(err_src);
        rxf_n_d = (DEPTH_CNT - h2d_count_next) < SLACK_CNT;
        // txe_n drops only once the head byte has been resident a full cycle.
        txe_n_d = (d2h_count_next == '0) || d2h_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_n_q <= 1'b1;
            txe_n_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            rxf_n_q <= rxf_n_d;
            txe_n_q <= txe_n_d;
            err_q   <= err_d;
        end
    end

    assign rxf_n = rxf_n_q;
    assign txe_n = txe_n_q;
    assign err   = err_q;

endmodule
